// File: rtl/tcdm_bank_responder_if.sv
// TCDM request/response bundle between the CGRA initiator ports and the banked scratchpad.
interface tcdm_bank_responder_if #(
    parameter int unsigned NrPorts   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NrBanks   = 32,
    parameter int unsigned TCDMDepth = 64
);
    localparam int unsigned TCDMSize      = NrBanks * TCDMDepth * (DataWidth / 8);
    localparam int unsigned TCDMAddrWidth = $clog2(TCDMSize);

    logic [NrPorts-1:0]                        tcdm_req_q_valid;
    logic [NrPorts-1:0]                        tcdm_req_write;
    logic [NrPorts-1:0][TCDMAddrWidth-1:0]     tcdm_req_addr;
    logic [NrPorts-1:0][DataWidth-1:0]         tcdm_req_data;
    logic [NrPorts-1:0][DataWidth/8-1:0]       tcdm_req_strb;
    logic [NrPorts-1:0]                        tcdm_req_amo;
    logic [NrPorts-1:0]                        tcdm_rsp_q_ready;
    logic [NrPorts-1:0]                        tcdm_rsp_p_valid;
    logic [NrPorts-1:0][DataWidth-1:0]         tcdm_rsp_data;

    modport master (
        output tcdm_req_q_valid, tcdm_req_write, tcdm_req_addr, tcdm_req_data,
               tcdm_req_strb, tcdm_req_amo,
        input  tcdm_rsp_q_ready, tcdm_rsp_p_valid, tcdm_rsp_data
    );

    modport slave (
        input  tcdm_req_q_valid, tcdm_req_write, tcdm_req_addr, tcdm_req_data,
               tcdm_req_strb, tcdm_req_amo,
        output tcdm_rsp_q_ready, tcdm_rsp_p_valid, tcdm_rsp_data
    );
endinterface

// File: rtl/tcdm_bank_responder.sv
// Word-interleaved multi-port scratchpad: per-bank round-robin arbitration,
// byte-strobed writes, one-cycle read latency.

module tcdm_bank_responder_bank #(
    parameter int unsigned NrPorts   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned RowW      = 6,
    localparam int unsigned StrbW    = DataWidth / 8,
    localparam int unsigned PortW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrPorts-1:0]                req,
    input  logic [NrPorts-1:0]                write,
    input  logic [NrPorts-1:0][RowW-1:0]      row,
    input  logic [NrPorts-1:0][DataWidth-1:0] wdata,
    input  logic [NrPorts-1:0][StrbW-1:0]     strb,
    output logic [NrPorts-1:0]                gnt,
    output logic [DataWidth-1:0]              rdata
);
    logic [DataWidth-1:0] mem [2**RowW];
    logic [PortW-1:0]     rr_q, sel, idx;
    logic                 found;
    int                   t;

    // Scan ports starting at the pointer; first requester wins.
    always_comb begin
        gnt   = '0;
        sel   = '0;
        idx   = '0;
        t     = 0;
        found = 1'b0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            t = int'(rr_q) + i;
            if (t >= int'(NrPorts)) t = t - int'(NrPorts);
            idx = PortW'(t);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (found) gnt[sel] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (found) begin
            rr_q <= (int'(sel) == int'(NrPorts) - 1) ? '0 : sel + 1'b1;
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (found && write[sel]) begin
            for (int k = 0; k < int'(StrbW); k++) begin
                if (strb[sel][k]) mem[row[sel]][k*8 +: 8] <= wdata[sel][k*8 +: 8];
            end
        end
    end

    assign rdata = mem[row[sel]];
endmodule

module tcdm_bank_responder #(
    parameter int unsigned NrPorts       = 4,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned NrBanks       = 32,
    parameter int unsigned TCDMDepth     = 64,
    parameter int unsigned TCDMSize      = NrBanks * TCDMDepth * (DataWidth / 8),
    parameter int unsigned TCDMAddrWidth = $clog2(TCDMSize)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tcdm_bank_responder_if.slave tcdm
);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned BankW = $clog2(NrBanks);
    localparam int unsigned RowW  = $clog2(TCDMDepth);

    logic [NrPorts-1:0][BankW-1:0]     port_bank;
    logic [NrPorts-1:0][RowW-1:0]      port_row;
    logic [NrPorts-1:0][OffW-1:0]      port_off;
    logic [NrPorts-1:0]                port_gnt;
    logic [NrBanks-1:0][NrPorts-1:0]   bank_req, bank_gnt;
    logic [NrBanks-1:0][DataWidth-1:0] bank_rdata;
    logic [NrPorts-1:0]                rsp_valid_q;
    logic [NrPorts-1:0][DataWidth-1:0] rsp_data_q;
    logic                              unused_bits;

    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            port_off[p]  = tcdm.tcdm_req_addr[p][OffW-1:0];
            port_bank[p] = tcdm.tcdm_req_addr[p][OffW +: BankW];
            port_row[p]  = tcdm.tcdm_req_addr[p][OffW+BankW +: RowW];
        end
    end

    // Byte offset and atomic flag carry no meaning for this responder.
    assign unused_bits = ^{port_off, tcdm.tcdm_req_amo};

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < int'(NrBanks); b++) begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                bank_req[b][p] = tcdm.tcdm_req_q_valid[p] & rst_ni &
                                 (port_bank[p] == BankW'(b));
            end
        end
    end

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        tcdm_bank_responder_bank #(
            .NrPorts   (NrPorts),
            .DataWidth (DataWidth),
            .RowW      (RowW)
        ) i_bank (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req    (bank_req[b]),
            .write  (tcdm.tcdm_req_write),
            .row    (port_row),
            .wdata  (tcdm.tcdm_req_data),
            .strb   (tcdm.tcdm_req_strb),
            .gnt    (bank_gnt[b]),
            .rdata  (bank_rdata[b])
        );
    end

    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            port_gnt[p] = bank_gnt[port_bank[p]][p];
        end
    end

    assign tcdm.tcdm_rsp_q_ready = port_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                rsp_valid_q[p] <= port_gnt[p] & ~tcdm.tcdm_req_write[p];
                if (port_gnt[p] && !tcdm.tcdm_req_write[p])
                    rsp_data_q[p] <= bank_rdata[port_bank[p]];
            end
        end
    end

    assign tcdm.tcdm_rsp_p_valid = rsp_valid_q;
    assign tcdm.tcdm_rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with hand-computed expectations.
module tb_tcdm_bank_responder;
    localparam int NP = 4;
    localparam int AW = 14;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk_i = ~clk_i;

    tcdm_bank_responder_if #(.NrPorts(NP)) bus ();

    tcdm_bank_responder #(.NrPorts(NP)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tcdm   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic clr();
        bus.tcdm_req_q_valid = '0;
        bus.tcdm_req_write   = '0;
        bus.tcdm_req_addr    = '0;
        bus.tcdm_req_data    = '0;
        bus.tcdm_req_strb    = '0;
        bus.tcdm_req_amo     = '0;
    endtask

    task automatic req(input int p, input logic wr, input logic [AW-1:0] a,
                       input logic [63:0] d, input logic [7:0] s);
        bus.tcdm_req_q_valid[p] = 1'b1;
        bus.tcdm_req_write[p]   = wr;
        bus.tcdm_req_addr[p]    = a;
        bus.tcdm_req_data[p]    = d;
        bus.tcdm_req_strb[p]    = s;
    endtask

    // Advance one edge; leave the bench on the falling edge for sampling.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        clr();
        req(0, 1'b0, 14'h010, '0, '0);
        #3;
        chk("rst_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'd0);
        chk("rst_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'd0);
        chk("rst_data0", bus.tcdm_rsp_data[0], 64'd0);
        chk("rst_data3", bus.tcdm_rsp_data[3], 64'd0);
        clr();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single write then read
        req(0, 1'b1, 14'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        #1 chk("wr_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'h1);
        step(); clr();
        chk("wr_no_rsp", {60'd0, bus.tcdm_rsp_p_valid}, 64'd0);
        req(0, 1'b0, 14'h010, '0, '0);
        #1 chk("rd_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'h1);
        step(); clr();
        chk("rd_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'h1);
        chk("rd_data", bus.tcdm_rsp_data[0], 64'hDEADBEEF_CAFEF00D);
        step();
        chk("hold_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'd0);
        chk("hold_data", bus.tcdm_rsp_data[0], 64'hDEADBEEF_CAFEF00D);

        // strobe merge, then an all-zero strobe write that must change nothing
        req(0, 1'b1, 14'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); step(); clr();
        req(0, 1'b1, 14'h100, 64'h0, 8'h0F); step(); clr();
        chk("wr_keeps_data", bus.tcdm_rsp_data[0], 64'hDEADBEEF_CAFEF00D);
        req(0, 1'b0, 14'h100, '0, '0); step(); clr();
        chk("strb_merge", bus.tcdm_rsp_data[0], 64'hFFFF_FFFF_0000_0000);
        req(0, 1'b1, 14'h100, 64'h5555_5555_5555_5555, 8'h00);
        #1 chk("zstrb_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'h1);
        step(); clr();
        req(0, 1'b0, 14'h100, '0, '0); step(); clr();
        chk("zstrb_data", bus.tcdm_rsp_data[0], 64'hFFFF_FFFF_0000_0000);

        // parallel, conflict-free banks 0..3
        req(0, 1'b1, 14'h000, 64'hA0, 8'hFF);
        req(1, 1'b1, 14'h008, 64'hA1, 8'hFF);
        req(3, 1'b1, 14'h018, 64'hA3, 8'hFF);
        #1 chk("par_wr_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'hB);
        step(); clr();
        req(0, 1'b0, 14'h000, '0, '0);
        req(1, 1'b0, 14'h008, '0, '0);
        req(2, 1'b0, 14'h010, '0, '0);
        req(3, 1'b0, 14'h018, '0, '0);
        #1 chk("par_rd_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'hF);
        step(); clr();
        chk("par_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'hF);
        chk("par_d0", bus.tcdm_rsp_data[0], 64'hA0);
        chk("par_d1", bus.tcdm_rsp_data[1], 64'hA1);
        chk("par_d2", bus.tcdm_rsp_data[2], 64'hDEADBEEF_CAFEF00D);
        chk("par_d3", bus.tcdm_rsp_data[3], 64'hA3);

        // bank 5 preload from port 3 leaves that bank's pointer at 0
        for (int i = 0; i < 4; i++) begin
            req(3, 1'b1, AW'(14'h028 + 14'h100 * i), 64'h500 + 64'(i), 8'hFF);
            step(); clr();
        end
        for (int i = 0; i < 4; i++)
            req(i, 1'b0, AW'(14'h028 + 14'h100 * i), '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rr_ready%0d", i), {60'd0, bus.tcdm_rsp_q_ready}, 64'(1) << i);
            step();
            bus.tcdm_req_q_valid[i] = 1'b0;
            chk($sformatf("rr_pvalid%0d", i), {60'd0, bus.tcdm_rsp_p_valid}, 64'(1) << i);
            chk($sformatf("rr_data%0d", i), bus.tcdm_rsp_data[i], 64'h500 + 64'(i));
        end
        clr();

        // read-after-write across ports on bank 8
        req(1, 1'b1, 14'h040, 64'h1234, 8'hFF);
        #1 chk("raw_wr_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'h2);
        step(); clr();
        req(2, 1'b0, 14'h040, '0, '0);
        #1 chk("raw_rd_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'h4);
        step(); clr();
        chk("raw_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'h4);
        chk("raw_data", bus.tcdm_rsp_data[2], 64'h1234);

        // reset while a read response is outstanding
        req(0, 1'b0, 14'h010, '0, '0);
        step(); clr();
        chk("pre_rst_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'h1);
        rst_ni = 1'b0;
        req(1, 1'b0, 14'h040, '0, '0);
        #1;
        chk("mid_rst_pvalid", {60'd0, bus.tcdm_rsp_p_valid}, 64'd0);
        chk("mid_rst_data", bus.tcdm_rsp_data[0], 64'd0);
        chk("mid_rst_ready", {60'd0, bus.tcdm_rsp_q_ready}, 64'd0);
        clr();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        req(0, 1'b0, 14'h010, '0, '0);
        step(); clr();
        chk("post_rst_data", bus.tcdm_rsp_data[0], 64'hDEADBEEF_CAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
